imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Byte-stream program loader sitting directly upstream of the cpu's instruction memory. It receives a framed byte stream (length, payload, checksum) over a valid/ready interface. It assembles little-endian 32-bit words and writes them sequentially into instruction memory through a single-cycle write port. The cpu is held in reset (cpu_rst_n low) until a complete, checksum-verified image is loaded; it is released so that it fetches from PC 0x0000_0000.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; maximum image is 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse: abort or finish current load and begin a new frame
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte; byte transferred when in_valid && in_ready
imem_we  output  1  instruction-memory write enable, one cycle per word
imem_addr  output  ADDR_WIDTH  word address of write
imem_wdata  output  32  word to write
cpu_rst_n  output  1  active-low reset to cpu; low while loading
done  output  1  image loaded and verified; level
error  output  1  frame rejected; level

Behaviour:
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N payload bytes (each word LSB first), 1 checksum byte = XOR of all payload bytes only.
- FSM states: S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR. Reset state is S_LEN0.
- Reset values: in_ready 0 during rst; imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst_n 0, done 0, error 0. Internal word counter, byte index and checksum accumulator are 0.
- in_ready = 1 in S_LEN0/S_LEN1/S_DATA/S_CSUM when start = 0. in_ready = 0 in S_DONE and S_ERR, and in any cycle where start = 1.
- S_LEN0: accept byte -> len[7:0], go S_LEN1.
- S_LEN1: accept byte -> len[15:8]. Transition depends on len:
  - len > 2**ADDR_WIDTH: go S_ERR.
  - len == 0: go S_CSUM.
  - otherwise: go S_DATA.
- S_DATA: each accepted byte shifts into the word buffer at byte lane = byte index (0..3) and is XORed into the checksum.
  - On the 4th byte, the next cycle drives imem_we = 1, imem_wdata = assembled word, imem_addr = word counter. This is registered with 1-cycle latency.
  - The word counter increments; the byte index wraps to 0.
  - After word N-1's 4th byte, go S_CSUM.
  - Back-to-back bytes (in_valid held high) are accepted every cycle with no stall. Writes never overlap because each word needs 4 accept cycles.
- S_CSUM: accept byte. If it equals the accumulator, go S_DONE; otherwise go S_ERR.
- S_DONE: done = 1 and cpu_rst_n = 1, both registered, rising on the same edge that enters S_DONE. This is 1 cycle after the checksum byte is accepted. The final imem write completes at or before this edge.
- S_ERR: error = 1, cpu_rst_n stays 0. Already-written words are left in memory, not cleared.
- start (any state): next edge goes to S_LEN0, clears counters, checksum, done and error, and drives cpu_rst_n = 0. Any pending imem_we is cancelled.
- in_valid gaps: state and partial word hold indefinitely. There is no timeout.
- rst mid-load: immediate return to reset values on the next edge; a partial word is discarded and no write is issued.
- Max length N = 2**ADDR_WIDTH: the final imem_addr is 2**ADDR_WIDTH-1. The counter must not wrap before S_CSUM.

Test Plan:
- Nominal 2-word load, bytes 02 00 | 03 29 C0 00 | 23 28 20 01 | C0 -> imem writes addr0 = 0x00C02903, addr1 = 0x01202823. Exactly 2 imem_we pulses. done = 1 and cpu_rst_n = 1 one cycle after the C0 byte; error = 0.
- Same frame with checksum 0xC1 -> error = 1, done = 0, cpu_rst_n stays 0, in_ready = 0 afterwards.
- Length 0x0000 followed by checksum 00 -> no imem_we, done = 1. With ADDR_WIDTH = 8, length 0x0101 -> S_ERR right after LEN_HI, no payload accepted.
- Random in_valid gaps (e.g. 1-5 idle cycles between bytes) on the nominal frame -> identical writes and result. Each imem_we pulse occurs exactly 1 cycle after the 4th byte of its word.
- Start pulse mid-payload (after 6 bytes), then a full nominal frame -> cpu_rst_n low throughout. Writes restart at addr 0; final done = 1. No byte is accepted in the start cycle.
- rst asserted in S_DONE -> all outputs return to reset values next edge. A following full frame loads correctly.

Source files
------------

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a framed, XOR-checksummed byte stream into instruction
//               memory as little-endian words, holding the cpu in reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_LEN0 = 3'd0;
    localparam logic [2:0] S_LEN1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [16:0] c_MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [16:0]           r_word_cnt;
    logic [1:0]            r_byte_idx;
    logic [7:0]            r_csum;
    logic [23:0]           r_buf;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;

    logic                  w_accept;
    logic [15:0]           w_len_full;
    logic                  w_last_word;

    assign w_accept   = in_valid & in_ready;
    assign w_len_full = {in_data, r_len_lo};
    // Counter is one bit wider than the address so a full-size image never wraps.
    assign w_last_word = (r_byte_idx == 2'd3) && ((r_word_cnt + 17'd1) == {1'b0, r_len});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = S_LEN0;
        end else begin
            case (r_state)
                S_LEN0: if (w_accept) w_next_state = S_LEN1;
                S_LEN1: begin
                    if (w_accept) begin
                        if ({1'b0, w_len_full} > c_MAX_WORDS) begin
                            w_next_state = S_ERR;
                        end else if (w_len_full == 16'd0) begin
                            w_next_state = S_CSUM;
                        end else begin
                            w_next_state = S_DATA;
                        end
                    end
                end
                S_DATA: if (w_accept && w_last_word) w_next_state = S_CSUM;
                S_CSUM: if (w_accept) w_next_state = (in_data == r_csum) ? S_DONE : S_ERR;
                S_DONE: w_next_state = S_DONE;
                S_ERR:  w_next_state = S_ERR;
                default: w_next_state = S_LEN0;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_rst_n = 1'b0;
        case (r_state)
            S_LEN0, S_LEN1, S_DATA, S_CSUM: in_ready = ~rst & ~start;
            S_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            S_ERR:  error = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_word_cnt   <= 17'd0;
            r_byte_idx   <= 2'd0;
            r_csum       <= 8'd0;
            r_buf        <= 24'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_LEN0: r_len_lo <= in_data;
                    S_LEN1: r_len    <= w_len_full;
                    S_DATA: begin
                        r_csum     <= r_csum ^ in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_buf[7:0]   <= in_data;
                            2'd1: r_buf[15:8]  <= in_data;
                            2'd2: r_buf[23:16] <= in_data;
                            default: begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                                r_imem_wdata <= {in_data, r_buf};
                                r_word_cnt   <= r_word_cnt + 17'd1;
                            end
                        endcase
                    end
                    default: r_len_lo <= r_len_lo;
                endcase
            end
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Randomized frame stimulus checked every cycle against a
//               frame-level model of the loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

    localparam int AW        = 8;
    localparam int MAX_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic          done;
    logic          error;

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: status 0 = loading, 1 = done, 2 = error.
    logic        armed = 1'b0;
    int          m_status = 0;
    int          m_k = 0;
    int          m_n = 0;
    logic [7:0]  m_csum = 8'd0;
    logic [31:0] m_word = 32'd0;
    logic        m_we = 1'b0;
    logic        m_reset = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_data = 32'd0;

    logic [31:0] mem [MAX_WORDS];
    int          wr_count = 0;

    always @(negedge clk) begin
        logic exp_ready;
        int   p;
        exp_ready = !rst && !start && (m_status == 0);
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("imem_we", 32'(imem_we), 32'(m_we));
            if (m_we) begin
                chk("imem_addr", 32'(imem_addr), 32'(m_addr));
                chk("imem_wdata", imem_wdata, m_data);
            end else if (m_reset) begin
                chk("rst_addr", 32'(imem_addr), 32'd0);
                chk("rst_wdata", imem_wdata, 32'd0);
            end
            chk("done", 32'(done), 32'(m_status == 1));
            chk("error", 32'(error), 32'(m_status == 2));
            chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_status == 1));
            if (imem_we === 1'b1) begin
                mem[imem_addr] = imem_wdata;
                wr_count++;
            end
        end
        if (rst) armed = 1'b1;
        if (rst || start) begin
            m_status = 0; m_k = 0; m_n = 0; m_csum = 8'd0;
            m_we = 1'b0; m_reset = rst;
        end else begin
            m_we = 1'b0; m_reset = 1'b0;
            if (in_valid && exp_ready) begin
                if (m_k == 0) begin
                    m_n = int'(in_data);
                end else if (m_k == 1) begin
                    m_n = m_n + 256 * int'(in_data);
                    if (m_n > MAX_WORDS) m_status = 2;
                end else begin
                    p = m_k - 2;
                    if (p < 4 * m_n) begin
                        m_word[8*(p%4) +: 8] = in_data;
                        m_csum = m_csum ^ in_data;
                        if (p % 4 == 3) begin
                            m_we = 1'b1; m_addr = p / 4; m_data = m_word;
                        end
                    end else begin
                        m_status = (in_data == m_csum) ? 1 : 2;
                    end
                end
                m_k++;
            end
        end
    end

    logic [7:0] frame[$];

    task automatic build_nominal(input logic [7:0] csum);
        frame = '{8'h02, 8'h00, 8'h03, 8'h29, 8'hC0, 8'h00, 8'h23, 8'h28, 8'h20, 8'h01};
        frame.push_back(csum);
    endtask

    task automatic build_random(input int n, input bit corrupt);
        logic [7:0] b;
        logic [7:0] cs;
        cs = 8'd0;
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            cs ^= b;
            frame.push_back(b);
        end
        frame.push_back(corrupt ? ~cs : cs);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bytes(input int cnt, input int maxgap);
        bit ok;
        int w;
        for (int i = 0; i < cnt; i++) begin
            in_valid = 1'b0;
            cycles($urandom_range(0, maxgap));
            in_valid = 1'b1;
            in_data  = frame[i];
            w = 0;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                w++;
            end while (!ok && w < 50);
            if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        cycles(3);
        rst = 1'b0;
        cycles(2);
        chk("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        // Nominal two-word image, back-to-back bytes.
        wr_count = 0;
        build_nominal(8'hC0);
        send_bytes(frame.size(), 0);
        cycles(2);
        chk("nom_wcount", 32'(wr_count), 32'd2);
        chk("nom_word0", mem[0], 32'h00C02903);
        chk("nom_word1", mem[1], 32'h01202823);
        chk("nom_done", 32'(done), 32'd1);

        // Same image with idle gaps between bytes.
        pulse_start();
        wr_count = 0;
        mem[0] = 32'd0; mem[1] = 32'd0;
        send_bytes(frame.size(), 5);
        cycles(2);
        chk("gap_wcount", 32'(wr_count), 32'd2);
        chk("gap_word1", mem[1], 32'h01202823);

        // Bad checksum.
        pulse_start();
        build_nominal(8'hC1);
        send_bytes(frame.size(), 1);
        cycles(2);
        chk("badcs_error", 32'(error), 32'd1);
        chk("badcs_ready", 32'(in_ready), 32'd0);

        // Empty image.
        pulse_start();
        wr_count = 0;
        frame = '{8'h00, 8'h00, 8'h00};
        send_bytes(3, 2);
        cycles(2);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_wcount", 32'(wr_count), 32'd0);

        // Oversize length rejected right after LEN_HI; further bytes refused.
        pulse_start();
        frame = '{8'h01, 8'h01};
        send_bytes(2, 0);
        in_valid = 1'b1; in_data = 8'hAA;
        cycles(3);
        in_valid = 1'b0;
        chk("oversize_error", 32'(error), 32'd1);

        // Start mid-payload (byte refused in the start cycle), then full image.
        pulse_start();
        build_nominal(8'hC0);
        send_bytes(6, 1);
        in_valid = 1'b1; in_data = 8'h55;
        pulse_start();
        in_valid = 1'b0;
        wr_count = 0;
        send_bytes(frame.size(), 2);
        cycles(2);
        chk("restart_wcount", 32'(wr_count), 32'd2);
        chk("restart_word0", mem[0], 32'h00C02903);

        // Reset while done, then reload.
        pulse_rst();
        send_bytes(frame.size(), 0);
        cycles(2);
        chk("post_rst_done", 32'(done), 32'd1);

        // Reset mid-load discards the partial frame.
        pulse_start();
        build_random(4, 1'b0);
        send_bytes(9, 1);
        pulse_rst();
        send_bytes(frame.size(), 1);
        cycles(2);
        chk("rst_mid_done", 32'(done), 32'd1);

        // Randomized frames, last one at maximum length.
        for (int it = 0; it < 8; it++) begin
            pulse_start();
            wr_count = 0;
            if (it == 7) build_random(MAX_WORDS, 1'b0);
            else build_random($urandom_range(0, 12), 1'($urandom_range(0, 1)));
            send_bytes(frame.size(), (it == 7) ? 1 : 4);
            cycles(2);
        end
        chk("max_wcount", 32'(wr_count), 32'(MAX_WORDS));
        chk("max_done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
